window3x3_gen: RTL and testbench

Streaming 3x3 neighbourhood generator that produces the nine-pixel window consumed by the combinational median filter in the VGA pixel path. It accepts one raster-order pixel per valid cycle, buffers two previous lines internally, and presents p0..p8 (row-major, p0 top-left, p4 centre, p8 bottom-right) with a registered valid. It emits only fully interior windows, so the downstream filter never sees padded data.

---
 rtl/vga_pkg.sv | 14 +
 rtl/window3x3_gen_line_buffer.sv | 24 ++
 rtl/window3x3_gen.sv | 167 ++++++++++++++++
 tb/tb_window3x3_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared defaults and FSM encoding for the VGA pixel-path blocks.
package vga_pkg;

  localparam int DEF_BIT_WIDTH  = 8;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/window3x3_gen_line_buffer.sv
// Single-line pixel store: one write port and one combinational read port
// sharing the same address. Contents are intentionally not reset.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read-before-write: rdata shows the old entry during the write cycle.
  assign rdata = mem[addr];

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift array,
// emitting only interior windows one cycle after the completing pixel.
module window3x3_gen
  import vga_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [BIT_WIDTH-1:0] in_pixel,
  output logic                 out_valid,
  output logic                 out_eof,
  output logic [BIT_WIDTH-1:0] p0,
  output logic [BIT_WIDTH-1:0] p1,
  output logic [BIT_WIDTH-1:0] p2,
  output logic [BIT_WIDTH-1:0] p3,
  output logic [BIT_WIDTH-1:0] p4,
  output logic [BIT_WIDTH-1:0] p5,
  output logic [BIT_WIDTH-1:0] p6,
  output logic [BIT_WIDTH-1:0] p7,
  output logic [BIT_WIDTH-1:0] p8
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        col_q, col_d, pix_col;
  logic [RW-1:0]        row_q, row_d, pix_row;
  logic                 accept, last_pix, emit;
  logic [BIT_WIDTH-1:0] lb0_rd, lb1_rd;
  logic [BIT_WIDTH-1:0] win_q [3][3];
  logic [BIT_WIDTH-1:0] win_d [3][3];
  logic [BIT_WIDTH-1:0] pix_q [9];
  logic [BIT_WIDTH-1:0] pix_d [9];
  logic                 out_valid_q, out_valid_d;
  logic                 out_eof_q, out_eof_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A start-of-frame always wins, even on what would be the last pixel.
  always_comb begin
    state_d = state_q;
    if (in_valid && in_sof) begin
      state_d = ST_ACTIVE;
    end else begin
      case (state_q)
        ST_ACTIVE: if (in_valid && last_pix) state_d = ST_DONE;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    accept   = in_valid && (in_sof || (state_q == ST_ACTIVE));
    pix_col  = in_sof ? '0 : col_q;
    pix_row  = in_sof ? '0 : row_q;
    last_pix = (pix_col == COL_LAST) && (pix_row == ROW_LAST);
    emit     = accept && (pix_row >= RW'(2)) && (pix_col >= CW'(2));
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (pix_col == COL_LAST) begin
        col_d = '0;
        row_d = (pix_row == ROW_LAST) ? '0 : pix_row + RW'(1);
      end else begin
        col_d = pix_col + CW'(1);
        row_d = pix_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // lb1 holds row-2, lb0 holds row-1; lb0's old entry cascades into lb1.
  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(BIT_WIDTH), .AW(CW)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (pix_col),
    .wdata (in_pixel),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(BIT_WIDTH), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (pix_col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = in_pixel;
    end
  end

  // Window data needs no reset; the row/col gating keeps stale taps hidden.
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  always_comb begin
    pix_d       = pix_q;
    out_valid_d = emit;
    out_eof_d   = emit && last_pix;
    if (emit) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          pix_d[r*3 + c] = win_d[r][c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      for (int k = 0; k < 9; k++) pix_q[k] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_eof_q   <= out_eof_d;
      pix_q       <= pix_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_eof   = out_eof_q;
  assign p0 = pix_q[0];
  assign p1 = pix_q[1];
  assign p2 = pix_q[2];
  assign p3 = pix_q[3];
  assign p4 = pix_q[4];
  assign p5 = pix_q[5];
  assign p6 = pix_q[6];
  assign p7 = pix_q[7];
  assign p8 = pix_q[8];

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed and randomized bench for window3x3_gen on a 5x4 image, checked
// against a frame-array reference model.
module tb_window3x3_gen;

  localparam int BW = 8;
  localparam int W  = 5;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_sof;
  logic [BW-1:0] in_pixel;
  logic          out_valid;
  logic          out_eof;
  logic [BW-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic [BW-1:0] dp [9];

  always #5 clk = ~clk;

  window3x3_gen #(.BIT_WIDTH(BW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_pixel (in_pixel),
    .out_valid(out_valid),
    .out_eof  (out_eof),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4),
    .p5(p5), .p6(p6), .p7(p7), .p8(p8)
  );

  assign dp[0] = p0;
  assign dp[1] = p1;
  assign dp[2] = p2;
  assign dp[3] = p3;
  assign dp[4] = p4;
  assign dp[5] = p5;
  assign dp[6] = p6;
  assign dp[7] = p7;
  assign dp[8] = p8;

  int checks = 0;
  int errors = 0;

  // Reference model: frame image indexed by (row, col) plus a frame cursor.
  bit            m_active;
  int            m_r, m_c;
  logic [BW-1:0] img [H][W];
  logic [BW-1:0] exp_p [9];
  logic          exp_v, exp_eof;

  int            dut_cnt;
  bit            prev_v;
  bit            no_b2b;
  bit            got_first;
  logic [BW-1:0] first_win [9];
  logic [BW-1:0] eof_p4;
  logic [BW-1:0] spec_first [9];

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input bit v, input bit s, input logic [BW-1:0] px);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_pixel = px;
    exp_v    = 1'b0;
    exp_eof  = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0;
      m_r = 0;
      m_c = 0;
      for (int k = 0; k < 9; k++) exp_p[k] = '0;
    end else if (v && (s || m_active)) begin
      if (s) begin
        m_r = 0;
        m_c = 0;
      end
      m_active = 1'b1;
      img[m_r][m_c] = px;
      if (m_r >= 2 && m_c >= 2) begin
        exp_v   = 1'b1;
        exp_eof = (m_r == H-1) && (m_c == W-1);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_p[r*3 + c] = img[m_r-2+r][m_c-2+c];
      end
      if (m_r == H-1 && m_c == W-1) begin
        m_active = 1'b0;
        m_r = 0;
        m_c = 0;
      end else if (m_c == W-1) begin
        m_c = 0;
        m_r++;
      end else begin
        m_c++;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", {7'd0, out_valid}, {7'd0, exp_v});
    chk("out_eof", {7'd0, out_eof}, {7'd0, exp_eof});
    for (int k = 0; k < 9; k++) chk($sformatf("p%0d", k), dp[k], exp_p[k]);
    if (out_valid) begin
      dut_cnt++;
      if (!got_first) begin
        got_first = 1'b1;
        for (int k = 0; k < 9; k++) first_win[k] = dp[k];
      end
      if (out_eof) eof_p4 = p4;
    end
    if (no_b2b) chk("no_back_to_back", {7'd0, out_valid && prev_v}, 8'd0);
    prev_v = out_valid;
  endtask

  task automatic send_pixels(input logic [BW-1:0] base, input int n, input int gap_mode, input bit rnd);
    logic [BW-1:0] px;
    for (int i = 0; i < n; i++) begin
      px = rnd ? BW'($urandom) : base + BW'((i / W) * 16 + (i % W));
      step(1'b1, i == 0, px);
      if (gap_mode == 1) step(1'b0, 1'b0, BW'($urandom));
      else if (gap_mode == 2) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, BW'($urandom));
    end
  endtask

  initial begin
    spec_first[0] = 8'h00; spec_first[1] = 8'h01; spec_first[2] = 8'h02;
    spec_first[3] = 8'h10; spec_first[4] = 8'h11; spec_first[5] = 8'h12;
    spec_first[6] = 8'h20; spec_first[7] = 8'h21; spec_first[8] = 8'h22;
    no_b2b    = 1'b0;
    prev_v    = 1'b0;
    got_first = 1'b0;
    dut_cnt   = 0;
    eof_p4    = '0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pixel  = '0;

    // 1: reset then a continuous frame
    rst_n = 1'b0;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0);
    send_pixels(8'h00, W*H, 0, 1'b0);
    step(1'b0, 1'b0, '0);
    chk("t1_window_count", BW'(dut_cnt), 8'd6);
    for (int k = 0; k < 9; k++) chk($sformatf("t1_first_p%0d", k), first_win[k], spec_first[k]);
    chk("t1_eof_p4", eof_p4, 8'h23);

    // 2: same frame with a one-cycle gap after every pixel
    dut_cnt = 0; got_first = 1'b0; no_b2b = 1'b1;
    send_pixels(8'h00, W*H, 1, 1'b0);
    no_b2b = 1'b0;
    chk("t2_window_count", BW'(dut_cnt), 8'd6);
    for (int k = 0; k < 9; k++) chk($sformatf("t2_first_p%0d", k), first_win[k], spec_first[k]);

    // 3: pixels without sof after reset are ignored
    rst_n = 1'b0;
    step(1'b0, 1'b0, '0);
    rst_n = 1'b1;
    dut_cnt = 0;
    for (int i = 0; i < 2*W+4; i++) step(1'b1, 1'b0, BW'(i));
    chk("t3_no_sof_count", BW'(dut_cnt), 8'd0);
    send_pixels(8'h00, W*H, 0, 1'b0);
    chk("t3_window_count", BW'(dut_cnt), 8'd6);

    // 4: trailing pixels after frame end, then a second frame offset by 0x80
    dut_cnt = 0;
    for (int i = 0; i < W*H; i++) step(1'b1, 1'b0, BW'($urandom));
    chk("t4_trailing_count", BW'(dut_cnt), 8'd0);
    got_first = 1'b0;
    send_pixels(8'h80, W*H, 0, 1'b0);
    chk("t4_first_p4", first_win[4], 8'h91);
    chk("t4_window_count", BW'(dut_cnt), 8'd6);

    // 5: sof arrives at pixel (2,3) of a frame
    send_pixels(8'h00, 2*W+3, 0, 1'b0);
    dut_cnt = 0;
    send_pixels(8'h40, W*H, 0, 1'b0);
    chk("t5_restart_count", BW'(dut_cnt), 8'd6);

    // 6: reset pulse at pixel (3,2) clears outputs; later pixels need sof
    send_pixels(8'h00, 3*W+2, 0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 8'h32);
    rst_n = 1'b1;
    chk("t6_rst_valid", {7'd0, out_valid}, 8'd0);
    chk("t6_rst_p4", p4, 8'd0);
    dut_cnt = 0;
    step(1'b1, 1'b0, 8'h33);
    step(1'b1, 1'b0, 8'h34);
    for (int i = 0; i < W*H; i++) step(1'b1, 1'b0, BW'($urandom));
    chk("t6_ignored_count", BW'(dut_cnt), 8'd0);

    // Randomized frames with random data and random gaps
    for (int f = 0; f < 4; f++) begin
      dut_cnt = 0;
      send_pixels(8'h00, W*H, 2, 1'b1);
      step(1'b0, 1'b0, '0);
      chk($sformatf("rnd%0d_window_count", f), BW'(dut_cnt), 8'd6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
